// File: rtl/mru_pkg.sv
// Shared types and the round-robin pick for the mru access front end.
// Pure declarations; no state, no latency, no flow control.
package mru_pkg;
  localparam int N_REQ_DEFAULT = 5;

  typedef logic [N_REQ_DEFAULT-1:0] req_vec_t;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} sched_state_t;

  // First set bit of pend scanning last+1, last+2, ... modulo n (n <= 32).
  function automatic int rr_pick(input logic [31:0] pend, input int last, input int n);
    int   idx;
    int   pick;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      idx = (last + k) % n;
      if (k <= n && !found && pend[idx[4:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/mru_debounce.sv
// One button bit: two-flop synchroniser, consecutive-cycle debounce and a 0->1 pulse.
// rise_o is high in the cycle whose clock edge flips the debounced level high; no backpressure.
module mru_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);
  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  always_comb begin
    meta_d = btn_i;
    sync_d = meta_q;
    db_d   = db_q;
    cnt_d  = '0;
    flip   = (sync_q != db_q) && (cnt_q == CNT_LAST);
    if (flip) begin
      db_d = sync_q;
    end else if (sync_q != db_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_o = flip & sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/mru_access_sched.sv
// Debounced button presses become pending requests, served round-robin as one-hot strobes.
// Access offered one cycle after pend sets; held until acc_ready, then ISSUE_GAP idle cycles.
module mru_access_sched
  import mru_pkg::*;
#(
  parameter int N_REQ           = N_REQ_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ISSUE_GAP       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] btn,
  output logic             acc_valid,
  output logic [N_REQ-1:0] acc_onehot,
  input  logic             acc_ready,
  output logic [N_REQ-1:0] pend,
  output logic             busy
);
  localparam int            IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int            GW       = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [N_REQ-1:0] onehot_q, onehot_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [IW-1:0]    pick;
  logic [N_REQ-1:0] rise;

  for (genvar i = 0; i < N_REQ; i++) begin : g_db
    mru_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn[i]),
      .rise_o(rise[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    valid_d  = valid_q;
    onehot_d = onehot_q;
    last_d   = last_q;
    grant_d  = grant_q;
    gap_d    = gap_q;
    pick     = IW'(rr_pick(32'(pend_q), int'(last_q), N_REQ));
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          grant_d  = pick;
          onehot_d = N_REQ'(1) << pick;
          valid_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (acc_ready) begin
          pend_d   = pend_q & ~onehot_q;
          last_d   = grant_q;
          valid_d  = 1'b0;
          onehot_d = '0;
          gap_d    = '0;
          state_d  = (ISSUE_GAP > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new press on the edge that clears the same bit keeps it pending.
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      valid_q  <= 1'b0;
      onehot_q <= '0;
      last_q   <= IW'(N_REQ - 1);
      grant_q  <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      gap_q    <= gap_d;
    end
  end

  assign acc_valid  = valid_q;
  assign acc_onehot = onehot_q;
  assign pend       = pend_q;
  assign busy       = (state_q != IDLE);
endmodule
